// File: rtl/hash_checker.sv
// hash_checker: keeps a short shift-register history of upstream hashes and
// answers submissions by searching a snapshot of that history one entry per
// cycle. Consecutive misses drive a timed lockout during which no submission
// is accepted.
module hash_checker #(
    parameter int DEPTH       = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              cur_hash,
    input  logic                     hash_vld,
    input  logic                     sub_valid,
    input  logic [15:0]              sub_hash,
    output logic                     sub_ready,
    output logic                     res_valid,
    output logic                     res_match,
    output logic [$clog2(DEPTH)-1:0] res_age,
    output logic [1:0]               fail_cnt,
    output logic                     locked
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RESULT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH-1:0][15:0]  hist_q, hist_d;
    logic [CW-1:0]           hist_cnt_q, hist_cnt_d;
    logic [DEPTH-1:0][15:0]  snap_q, snap_d;
    logic [CW-1:0]           snap_cnt_q, snap_cnt_d;
    logic [15:0]             key_q, key_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [LW-1:0]           lock_cnt_q, lock_cnt_d;
    logic [1:0]              fail_cnt_q, fail_cnt_d;
    logic                    res_match_q, res_match_d;
    logic [AW-1:0]           res_age_q, res_age_d;
    logic                    sub_ready_q, sub_ready_d;
    logic                    res_valid_q, res_valid_d;
    logic                    locked_q, locked_d;

    // History shift register: shifts on every hash_vld regardless of FSM state.
    always_comb begin
        hist_d     = hist_q;
        hist_cnt_d = hist_cnt_q;
        if (hash_vld) begin
            hist_d = {hist_q[DEPTH-2:0], cur_hash};
            if (hist_cnt_q != CW'(DEPTH)) begin
                hist_cnt_d = hist_cnt_q + CW'(1);
            end else begin
                hist_cnt_d = hist_cnt_q;
            end
        end else begin
            hist_d     = hist_q;
            hist_cnt_d = hist_cnt_q;
        end
    end

    // Next-state and datapath: accept, search the snapshot, report, lock out.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        snap_cnt_d  = snap_cnt_q;
        key_d       = key_q;
        idx_d       = idx_q;
        lock_cnt_d  = lock_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        res_match_d = res_match_q;
        res_age_d   = res_age_q;
        case (state_q)
            ST_IDLE: begin
                // sub_ready is high exactly in IDLE, so sub_valid alone accepts.
                // The snapshot takes the pre-edge history, so a hash pushed on
                // this same edge is not part of the search.
                if (sub_valid) begin
                    key_d      = sub_hash;
                    snap_d     = hist_q;
                    snap_cnt_d = hist_cnt_q;
                    idx_d      = {AW{1'b0}};
                    state_d    = ST_SEARCH;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (snap_cnt_q == {CW{1'b0}}) begin
                    res_match_d = 1'b0;
                    res_age_d   = {AW{1'b0}};
                    state_d     = ST_RESULT;
                end else if (snap_q[idx_q] == key_q) begin
                    // Search runs newest-first, so the first hit is the lowest age.
                    res_match_d = 1'b1;
                    res_age_d   = idx_q;
                    state_d     = ST_RESULT;
                end else if ((CW'(idx_q) + CW'(1)) == snap_cnt_q) begin
                    res_match_d = 1'b0;
                    res_age_d   = {AW{1'b0}};
                    state_d     = ST_RESULT;
                end else begin
                    idx_d       = idx_q + AW'(1);
                    state_d     = ST_SEARCH;
                end
            end
            ST_RESULT: begin
                if (res_match_q) begin
                    fail_cnt_d = 2'd0;
                    state_d    = ST_IDLE;
                end else if ((fail_cnt_q + 2'd1) == 2'(MAX_FAIL)) begin
                    fail_cnt_d = fail_cnt_q + 2'd1;
                    lock_cnt_d = LW'(LOCK_CYCLES);
                    state_d    = ST_LOCK;
                end else begin
                    fail_cnt_d = fail_cnt_q + 2'd1;
                    state_d    = ST_IDLE;
                end
            end
            ST_LOCK: begin
                // Entered with LOCK_CYCLES loaded; leaving when the count would
                // reach zero gives exactly LOCK_CYCLES cycles in this state.
                if (lock_cnt_q <= LW'(1)) begin
                    lock_cnt_d = {LW{1'b0}};
                    fail_cnt_d = 2'd0;
                    state_d    = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - LW'(1);
                    state_d    = ST_LOCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of what the next state implies.
    always_comb begin
        sub_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_RESULT);
        locked_d    = (state_d == ST_LOCK);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hist_q      <= '0;
            hist_cnt_q  <= {CW{1'b0}};
            snap_q      <= '0;
            snap_cnt_q  <= {CW{1'b0}};
            key_q       <= 16'h0000;
            idx_q       <= {AW{1'b0}};
            lock_cnt_q  <= {LW{1'b0}};
            fail_cnt_q  <= 2'd0;
            res_match_q <= 1'b0;
            res_age_q   <= {AW{1'b0}};
            sub_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            hist_cnt_q  <= hist_cnt_d;
            snap_q      <= snap_d;
            snap_cnt_q  <= snap_cnt_d;
            key_q       <= key_d;
            idx_q       <= idx_d;
            lock_cnt_q  <= lock_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            res_match_q <= res_match_d;
            res_age_q   <= res_age_d;
            sub_ready_q <= sub_ready_d;
            res_valid_q <= res_valid_d;
            locked_q    <= locked_d;
        end
    end

    assign sub_ready = sub_ready_q;
    assign res_valid = res_valid_q;
    assign res_match = res_match_q;
    assign res_age   = res_age_q;
    assign fail_cnt  = fail_cnt_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_hash_checker.sv
// Self-checking bench for hash_checker: randomized pushes and submissions
// checked against a queue-based model of history, search and lockout.
module tb_hash_checker;

    localparam int DEPTH       = 4;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] cur_hash;
    logic        hash_vld;
    logic        sub_valid;
    logic [15:0] sub_hash;
    logic        sub_ready;
    logic        res_valid;
    logic        res_match;
    logic [1:0]  res_age;
    logic [1:0]  fail_cnt;
    logic        locked;

    int n_chk;
    int n_pass;

    logic [15:0] mhist[$];
    int          mfail;

    hash_checker #(.DEPTH(DEPTH), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cur_hash  (cur_hash),
        .hash_vld  (hash_vld),
        .sub_valid (sub_valid),
        .sub_hash  (sub_hash),
        .sub_ready (sub_ready),
        .res_valid (res_valid),
        .res_match (res_match),
        .res_age   (res_age),
        .fail_cnt  (fail_cnt),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock; the model history takes any push the DUT sees on this edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && hash_vld) begin
            mhist.push_front(cur_hash);
            if (mhist.size() > DEPTH) void'(mhist.pop_back());
        end
        #1;
    endtask

    task automatic push(input logic [15:0] h);
        hash_vld = 1'b1;
        cur_hash = h;
        tick();
        hash_vld = 1'b0;
    endtask

    // mode 0: no pushes, 1: random pushes, 2: push every cycle
    task automatic drive_push(input int mode, input logic [15:0] v);
        cur_hash = v;
        if (mode == 0)      hash_vld = 1'b0;
        else if (mode == 1) hash_vld = 1'($urandom_range(0, 1));
        else                hash_vld = 1'b1;
    endtask

    task automatic submit(input logic [15:0] h, input int mode, input logic [15:0] acc_push);
        logic [15:0] snap[$];
        int k, lat, exp_lat, n;
        logic exp_match;
        chk("sub_ready_before", {31'd0, sub_ready}, 32'd1);
        snap = mhist;
        k = -1;
        foreach (snap[i]) if (k < 0 && snap[i] == h) k = i;
        exp_match = (k >= 0);
        exp_lat   = exp_match ? k + 1 : ((snap.size() > 0) ? snap.size() : 1);
        sub_valid = 1'b1;
        sub_hash  = h;
        drive_push(mode, acc_push);
        tick();
        sub_valid = 1'b0;
        sub_hash  = 16'($urandom);
        lat = 0;
        while (!res_valid && lat < 20) begin
            drive_push(mode, 16'($urandom));
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("res_match", {31'd0, res_match}, {31'd0, exp_match});
        chk("res_age", {30'd0, res_age}, exp_match ? k : 0);
        drive_push(mode, 16'($urandom));
        tick();
        hash_vld = 1'b0;
        chk("res_valid_one_cycle", {31'd0, res_valid}, 32'd0);
        chk("res_match_hold", {31'd0, res_match}, {31'd0, exp_match});
        mfail = exp_match ? 0 : mfail + 1;
        chk("fail_cnt", {30'd0, fail_cnt}, mfail);
        chk("locked", {31'd0, locked}, (mfail == MAX_FAIL) ? 1 : 0);
        if (mfail == MAX_FAIL) begin
            sub_valid = 1'b1;
            sub_hash  = h;
            n = 0;
            while (locked && n < 20) begin
                chk("sub_ready_locked", {31'd0, sub_ready}, 32'd0);
                tick();
                n++;
            end
            sub_valid = 1'b0;
            mfail = 0;
            chk("lock_len", n, LOCK_CYCLES);
            chk("sub_ready_after_lock", {31'd0, sub_ready}, 32'd1);
            chk("fail_cnt_after_lock", {30'd0, fail_cnt}, 32'd0);
            tick();
            chk("no_result_from_lock", {31'd0, res_valid}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sub_ready"}, {31'd0, sub_ready}, 32'd1);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_res_match"}, {31'd0, res_match}, 32'd0);
        chk({tag, "_res_age"},   {30'd0, res_age},   32'd0);
        chk({tag, "_fail_cnt"},  {30'd0, fail_cnt},  32'd0);
        chk({tag, "_locked"},    {31'd0, locked},    32'd0);
    endtask

    initial begin
        logic [15:0] h;
        n_chk = 0; n_pass = 0; mfail = 0;
        rst_n = 1'b0; hash_vld = 1'b0; cur_hash = 16'h0000;
        sub_valid = 1'b0; sub_hash = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Empty history: miss after one cycle.
        submit(16'hABCD, 0, 16'h0000);

        // Directed match at age 2.
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        submit(16'h2222, 0, 16'h0000);

        // Three consecutive misses -> lockout.
        submit(16'hDEAD, 0, 16'h0000);
        submit(16'hBEEF, 0, 16'h0000);
        submit(16'hCAFE, 0, 16'h0000);

        // Value pushed on the acceptance edge is not searched; pushes continue.
        submit(16'h5555, 2, 16'h5555);

        // Randomized submissions drawn from history or random values.
        for (int i = 0; i < 30; i++) begin
            if (mhist.size() > 0 && $urandom_range(0, 1) == 1)
                h = mhist[$urandom_range(0, mhist.size() - 1)];
            else
                h = 16'($urandom);
            submit(h, int'($urandom_range(0, 2)), 16'($urandom));
            repeat ($urandom_range(0, 2)) push(16'($urandom));
        end

        // Duplicate entries: lowest age wins.
        push(16'h7777); push(16'h1234); push(16'h7777);
        submit(16'h7777, 0, 16'h0000);

        // Reset mid-search aborts the operation.
        push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
        sub_valid = 1'b1; sub_hash = 16'hFFFF;
        tick();
        sub_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsearch_reset");
        mhist.delete();
        mfail = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_res_after_reset", {31'd0, res_valid}, 32'd0);
        end
        submit(16'h7777, 0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
